// File: rtl/xpb_pkg.sv
// Shared constants and state encoding for the xpb carry-save accumulator.
// Holds the operand widths, term count and FSM states used by the top level and bench.
package xpb_pkg;

  localparam int WORD_W    = 1024;
  localparam int NUM_TERMS = 32;
  localparam int GUARD_W   = 8;
  localparam int CNT_W     = 6;
  localparam int OUT_W     = WORD_W + GUARD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } xpb_state_e;

endpackage

// File: rtl/csa_3_2.sv
// Bitwise 3:2 compressor: folds three W-bit operands into a sum word and a
// carry word that is already shifted left by one (top carry bit is dropped).
module csa_3_2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] d,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  assign s = a ^ b ^ d;
  assign c = ((a & b) | (a & d) | (b & d)) << 1;

endmodule

// File: rtl/xpb_csa_accum.sv
// Accumulates a base value and NUM_TERMS xpb words in carry-save form, one
// 3:2 compression per accepted term, and presents the redundant (sum, carry) pair.
module xpb_csa_accum
  import xpb_pkg::*;
#(
  parameter int P_WORD_W    = WORD_W,
  parameter int P_NUM_TERMS = NUM_TERMS,
  parameter int P_GUARD_W   = GUARD_W,
  parameter int P_CNT_W     = CNT_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_valid,
  output logic                           start_ready,
  input  logic [P_WORD_W-1:0]            base_in,
  input  logic                           term_valid,
  output logic                           term_ready,
  input  logic [P_WORD_W-1:0]            term_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [P_WORD_W+P_GUARD_W-1:0]  out_sum,
  output logic [P_WORD_W+P_GUARD_W-1:0]  out_carry,
  output logic                           busy,
  output logic [P_CNT_W-1:0]             term_count,
  output xpb_state_e                     state_dbg
);

  localparam int ACC_W = P_WORD_W + P_GUARD_W;
  localparam logic [P_CNT_W-1:0] LAST_CNT = P_CNT_W'(P_NUM_TERMS - 1);

  // The guard bits must absorb NUM_TERMS+1 full-width addends without wrapping.
  generate
    if ((2 ** P_GUARD_W) < (P_NUM_TERMS + 1)) begin : g_guard_chk
      $error("xpb_csa_accum: GUARD_W too small for NUM_TERMS");
    end
    if ((2 ** P_CNT_W) < P_NUM_TERMS) begin : g_cnt_chk
      $error("xpb_csa_accum: CNT_W too small for NUM_TERMS");
    end
  endgenerate

  xpb_state_e         state_q, state_d;
  logic [ACC_W-1:0]   sum_q, carry_q;
  logic [P_CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0]   csa_s, csa_c;

  csa_3_2 #(.W(ACC_W)) u_csa (
    .a (sum_q),
    .b (carry_q),
    .d ({{P_GUARD_W{1'b0}}, term_in}),
    .s (csa_s),
    .c (csa_c)
  );

  // Handshake: a beat transfers on a rising clk edge where valid and ready are
  // both high; every ready/valid output is a pure decode of the registered state.
  assign start_ready = (state_q == IDLE);
  assign term_ready  = (state_q == ACCUM);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign out_sum     = sum_q;
  assign out_carry   = carry_q;
  assign term_count  = cnt_q;
  assign state_dbg   = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid) state_d = ACCUM;
      ACCUM:   if (term_valid && (cnt_q == LAST_CNT)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sum_q   <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            sum_q   <= {{P_GUARD_W{1'b0}}, base_in};
            carry_q <= '0;
            cnt_q   <= '0;
          end
        end
        ACCUM: begin
          if (term_valid) begin
            sum_q   <= csa_s;
            carry_q <= csa_c;
            cnt_q   <= cnt_q + P_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xpb_csa_accum.sv
// Bench for xpb_csa_accum: table-driven jobs, random jobs with stalls, reset
// mid-job, ignored inputs and back-to-back jobs against an arithmetic model.
module tb_xpb_csa_accum;
  import xpb_pkg::*;

  localparam int W      = WORD_W;
  localparam int OW     = OUT_W;
  localparam int BUDGET = 200;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start_valid = 1'b0;
  logic              start_ready;
  logic [W-1:0]      base_in = '0;
  logic              term_valid = 1'b0;
  logic              term_ready;
  logic [W-1:0]      term_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [OW-1:0]     out_sum, out_carry;
  logic              busy;
  logic [CNT_W-1:0]  term_count;
  xpb_state_e        state_dbg;

  int checks = 0;
  int failures = 0;
  logic [OW-1:0] exp_q[$];
  logic [W-1:0]  job_terms [NUM_TERMS];

  typedef struct {
    string        name;
    logic [W-1:0] base;
    logic [W-1:0] term;
    logic [OW-1:0] total;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  xpb_csa_accum dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .base_in     (base_in),
    .term_valid  (term_valid),
    .term_ready  (term_ready),
    .term_in     (term_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carry   (out_carry),
    .busy        (busy),
    .term_count  (term_count),
    .state_dbg   (state_dbg)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act_hi=%0h act_lo=%0h exp_hi=%0h exp_lo=%0h", name,
               act[OW-1:OW-64], act[127:0], exp[OW-1:OW-64], exp[127:0]);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL timeout %s act=no_handshake exp=handshake", name);
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: plain integer sum of base and all job terms, no carry-save form.
  function automatic logic [OW-1:0] model_total(input logic [W-1:0] base);
    logic [OW-1:0] t;
    t = OW'(base);
    for (int i = 0; i < NUM_TERMS; i++) t = t + OW'(job_terms[i]);
    return t;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    start_valid = 1'b0;
    term_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_start(input logic [W-1:0] base);
    int n;
    n = 0;
    start_valid = 1'b1;
    base_in = base;
    while (!start_ready && n < BUDGET) begin
      tick();
      n++;
    end
    if (n >= BUDGET) timeout("start");
    tick();
    start_valid = 1'b0;
  endtask

  task automatic send_term(input logic [W-1:0] t, input int max_gap);
    int n;
    int gap;
    gap = $urandom_range(max_gap, 0);
    term_valid = 1'b0;
    repeat (gap) tick();
    n = 0;
    term_valid = 1'b1;
    term_in = t;
    while (!term_ready && n < BUDGET) begin
      tick();
      n++;
    end
    if (n >= BUDGET) timeout("term");
    tick();
    term_valid = 1'b0;
  endtask

  task automatic run_job(input string name, input logic [W-1:0] base, input int max_gap,
                         input int holdoff, output logic [OW-1:0] total);
    logic [OW-1:0] s0, c0;
    exp_q.push_back(model_total(base));
    send_start(base);
    check({name, "_ready_lat"}, OW'(term_ready), OW'(1));
    for (int i = 0; i < NUM_TERMS; i++) begin
      send_term(job_terms[i], max_gap);
      check({name, "_count"}, OW'(term_count), OW'(i + 1));
    end
    check({name, "_out_lat"}, OW'(out_valid), OW'(1));
    check({name, "_term_ready_done"}, OW'(term_ready), OW'(0));
    s0 = out_sum;
    c0 = out_carry;
    total = s0 + c0;
    check({name, "_total"}, total, exp_q.pop_front());
    check({name, "_carry_lsb"}, OW'(c0[0]), OW'(0));
    for (int i = 0; i < holdoff; i++) begin
      tick();
      check({name, "_hold_valid"}, OW'(out_valid), OW'(1));
      check({name, "_hold_sum"}, out_sum, s0);
      check({name, "_hold_carry"}, out_carry, c0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_idle_busy"}, OW'(busy), OW'(0));
    check({name, "_idle_ready"}, OW'(start_ready), OW'(1));
  endtask

  initial begin
    logic [OW-1:0] got, e1, e2, s0, c0;
    logic [W-1:0]  all_ones, b1, b2;
    all_ones = '1;

    vecs[0] = '{name: "t1_ones", base: '0, term: W'(1), total: OW'(32)};
    vecs[1] = '{name: "t2_max", base: all_ones, term: all_ones,
                total: OW'(33) * ((OW'(1) << W) - OW'(1))};
    vecs[2] = '{name: "zero_terms", base: W'(5), term: '0, total: OW'(5)};
    vecs[3] = '{name: "max_terms", base: '0, term: all_ones,
                total: OW'(32) * ((OW'(1) << W) - OW'(1))};
    vecs[4] = '{name: "top_bit", base: W'(1), term: W'(1) << (W - 1),
                total: (OW'(1) << (W + 4)) + OW'(1)};

    do_reset();
    check("rst_out_valid", OW'(out_valid), OW'(0));
    check("rst_busy", OW'(busy), OW'(0));
    check("rst_count", OW'(term_count), OW'(0));
    check("rst_start_ready", OW'(start_ready), OW'(1));
    check("rst_term_ready", OW'(term_ready), OW'(0));
    check("rst_state", OW'(state_dbg), OW'(IDLE));
    check("rst_sum", out_sum, '0);
    check("rst_carry", out_carry, '0);

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < NUM_TERMS; i++) job_terms[i] = vecs[v].term;
      run_job(vecs[v].name, vecs[v].base, 0, 0, got);
      check({vecs[v].name, "_table"}, got, vecs[v].total);
      if (v == 1) check("t2_high_bits", got >> 1030, '0);
    end

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NUM_TERMS; i++) job_terms[i] = rand_word();
      run_job("t3_stall", rand_word(), 3, 5, got);
    end

    for (int i = 0; i < NUM_TERMS; i++) job_terms[i] = rand_word();
    send_start(rand_word());
    for (int i = 0; i < 10; i++) send_term(job_terms[i], 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_state", OW'(state_dbg), OW'(IDLE));
    check("t4_busy", OW'(busy), OW'(0));
    check("t4_count", OW'(term_count), OW'(0));
    for (int i = 0; i < NUM_TERMS; i++) job_terms[i] = '0;
    run_job("t4_after", W'(5), 1, 0, got);
    check("t4_total", got, OW'(5));

    for (int i = 0; i < NUM_TERMS; i++) job_terms[i] = rand_word();
    b1 = rand_word();
    e1 = model_total(b1);
    send_start(b1);
    for (int i = 0; i < 10; i++) send_term(job_terms[i], 0);
    start_valid = 1'b1;
    base_in = rand_word();
    tick();
    tick();
    start_valid = 1'b0;
    check("t5_accum_count", OW'(term_count), OW'(10));
    check("t5_accum_state", OW'(state_dbg), OW'(ACCUM));
    for (int i = 10; i < NUM_TERMS; i++) send_term(job_terms[i], 0);
    check("t5_done_valid", OW'(out_valid), OW'(1));
    s0 = out_sum;
    c0 = out_carry;
    term_valid = 1'b1;
    term_in = rand_word();
    repeat (3) tick();
    term_valid = 1'b0;
    check("t5_done_count", OW'(term_count), OW'(NUM_TERMS));
    check("t5_done_sum", out_sum, s0);
    check("t5_done_carry", out_carry, c0);
    check("t5_done_state", OW'(state_dbg), OW'(DONE));
    check("t5_total", s0 + c0, e1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t5_idle", OW'(busy), OW'(0));

    for (int i = 0; i < NUM_TERMS; i++) job_terms[i] = rand_word();
    b1 = rand_word();
    b2 = rand_word();
    e1 = model_total(b1);
    out_ready = 1'b1;
    send_start(b1);
    start_valid = 1'b1;
    base_in = b2;
    for (int i = 0; i < NUM_TERMS; i++) send_term(job_terms[i], 0);
    check("t6_job1_valid", OW'(out_valid), OW'(1));
    check("t6_job1_total", out_sum + out_carry, e1);
    for (int i = 0; i < NUM_TERMS; i++) job_terms[i] = rand_word();
    e2 = model_total(b2);
    tick();
    check("t6_idle_gap", OW'(start_ready), OW'(1));
    tick();
    start_valid = 1'b0;
    check("t6_job2_start", OW'(term_ready), OW'(1));
    for (int i = 0; i < NUM_TERMS; i++) send_term(job_terms[i], 0);
    check("t6_job2_valid", OW'(out_valid), OW'(1));
    check("t6_job2_total", out_sum + out_carry, e2);
    tick();
    out_ready = 1'b0;
    check("t6_end_busy", OW'(busy), OW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
